dcache_wt: RTL and testbench
============================

Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the pipeline MEM stage and the 20-cycle data memory.
- Serves load hits in the same cycle.
- Load misses and all stores go through a request/ready handshake to memory, and the pipeline is stalled meanwhile.
- Keeps hit/miss counters for performance labs.

Parameters:
- LINES, 16: number of one-word lines; power of two, at least 2. IDX = log2(LINES).
- CNT_W, 16: width of the performance counters.

Ports:
- Clk  in  1  clock; all state changes on posedge.
- Rst  in  1  asynchronous, active-low reset.
- AddressM  in  32  byte address from MEM stage; bits [1:0] ignored.
- MemtoRegM  in  1  load request.
- MemWriteM  in  1  store request.
- WriteDataM  in  32  store data.
- ReadDataM  out  32  load data.
- StallMem  out  1  freezes the pipeline while high.
- mem_read_req  out  1  level read request to memory.
- mem_write_req  out  1  level write request to memory.
- mem_addr  out  32  latched request address.
- mem_wdata  out  32  latched store data.
- mem_rdata  in  32  memory read data; valid when mem_ready=1.
- mem_ready  in  1  one-cycle completion pulse from memory.
- hit_count  out  CNT_W  saturating count of load hits.
- miss_count  out  CNT_W  saturating count of load misses.

Behaviour:
- Address split: index = AddressM[IDX+1:2]; tag = AddressM[31:IDX+2]. Each line holds {valid, tag, data}.
- Reset (Rst=0, async): all valid bits cleared; state=IDLE; mem_read_req, mem_write_req, mem_addr, mem_wdata, ReadDataM, hit_count and miss_count all 0; StallMem=0. Tag and data arrays are not reset.
- Reset mid-transaction: the FSM returns to IDLE and the request is dropped. A late mem_ready arriving in IDLE is ignored.
- States: IDLE, RD_MISS, WR_THRU.
- IDLE, neither request: StallMem=0, no memory request.
- IDLE, load hit (valid and tag match): ReadDataM = line data (combinational). StallMem=0. hit_count +1. Stay IDLE.
- IDLE, load miss: StallMem=1 (combinational). Latch mem_addr={AddressM[31:2],2'b00}. miss_count +1. Go to RD_MISS.
- IDLE, store: StallMem=1. Latch mem_addr and mem_wdata=WriteDataM. If the line hits, update its data at this edge; otherwise leave the line untouched (no allocate). Go to WR_THRU.
- MemtoRegM and MemWriteM both high: treated as a load. This is illegal stimulus; the bench flags it.
- RD_MISS: mem_read_req=1.
  - mem_ready=0: StallMem=1.
  - mem_ready=1: StallMem=0 and ReadDataM=mem_rdata (bypass) in the same cycle. At the edge, fill the line (valid=1, tag, data), drop mem_read_req, go to IDLE.
- WR_THRU: mem_write_req=1.
  - mem_ready=0: StallMem=1.
  - mem_ready=1: StallMem=0. At the edge, drop mem_write_req and go to IDLE.
- Changes on AddressM, WriteDataM or the request inputs while in RD_MISS or WR_THRU are ignored; the latched values are used.
- Latency: load hit 0 stall cycles. Load miss and store stall until the mem_ready cycle inclusive of the request cycle; with 20-cycle memory, StallMem is high for 20 cycles.
- Counters saturate at all-ones and never wrap. Stores are not counted.
- mem_read_req and mem_write_req are never both high.
- ReadDataM holds its last value when no load is being served.

Decomposition:
- Package dcache_pkg: state enum {IDLE, RD_MISS, WR_THRU}; localparams IDX_W and TAG_W derived from LINES; line struct {valid, tag, data}.
- Sub-module dcache_array: LINES-entry storage with combinational read port, a synchronous write port (fill or store-hit update), and valid bits cleared by async reset.
- The FSM and counters live in dcache_wt.

Test Plan:
- Cold load 0x40, memory returns 0xDEADBEEF after 20 cycles -> StallMem high for 20 cycles; ReadDataM=0xDEADBEEF in the mem_ready cycle; miss_count=1.
- Repeat load 0x40 -> StallMem=0, ReadDataM=0xDEADBEEF same cycle, no mem_read_req, hit_count=1.
- Store 0x12345678 to 0x40 (hit) -> mem_write_req with mem_addr=0x40, mem_wdata=0x12345678 until ready; next load 0x40 hits with 0x12345678.
- Store to 0x80 (miss, LINES=16) -> write goes to memory, line not allocated; load 0x80 then misses (miss_count increments).
- Conflict: load 0x04 then load 0x44 (same index, different tag) -> second load misses and evicts; load 0x04 misses again.
- Drive Rst=0 during RD_MISS, then mem_ready pulses after release -> state IDLE, requests 0, counters 0, valid cleared, late ready ignored; load 0x40 misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared state encoding and line layout for the direct-mapped write-through data cache.
// Cache geometry is set here so the line struct width follows LINES automatically.
package dcache_pkg;
    localparam int LINES = 16;
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR_THRU
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } line_t;
endpackage

// File: rtl/dcache_array.sv
// Line storage for dcache_wt: combinational read port, one synchronous write port.
// Only the valid bits are reset; tag and data contents are meaningless until filled.
module dcache_array
    import dcache_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic [IDX_W-1:0] rd_idx,
    output line_t            rd_line,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  line_t            wr_line
);
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_line.valid;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_line.tag;
            data_q[wr_idx] <= wr_line.data;
        end
    end

    always_comb begin
        rd_line.valid = valid_q[rd_idx];
        rd_line.tag   = tag_q[rd_idx];
        rd_line.data  = data_q[rd_idx];
    end
endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with a stalling
// request/ready memory interface and saturating hit/miss counters.
module dcache_wt
    import dcache_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [31:0]      AddressM,
    input  logic             MemtoRegM,
    input  logic             MemWriteM,
    input  logic [31:0]      WriteDataM,
    output logic [31:0]      ReadDataM,
    output logic             StallMem,
    output logic             mem_read_req,
    output logic             mem_write_req,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    state_t           state;
    line_t            rd_line;
    line_t            wr_line;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] req_tag;
    logic             tag_match;
    logic             load_hit;
    logic             load_miss;
    logic             store;
    logic             fill;
    logic             wr_en;
    logic [31:0]      rdata_q;
    logic             addr_lsb_unused;

    assign addr_lsb_unused = ^AddressM[1:0];

    assign req_idx   = AddressM[IDX_W+1:2];
    assign req_tag   = AddressM[31:IDX_W+2];
    assign tag_match = rd_line.valid && (rd_line.tag == req_tag);
    // A simultaneous load and store request is resolved as a load.
    assign load_hit  = (state == IDLE) && MemtoRegM && tag_match;
    assign load_miss = (state == IDLE) && MemtoRegM && !tag_match;
    assign store     = (state == IDLE) && MemWriteM && !MemtoRegM;
    assign fill      = (state == RD_MISS) && mem_ready;
    assign wr_en     = fill || (store && tag_match);

    always_comb begin
        wr_idx       = req_idx;
        wr_line.valid = 1'b1;
        wr_line.tag  = req_tag;
        wr_line.data = WriteDataM;
        if (fill) begin
            wr_idx       = mem_addr[IDX_W+1:2];
            wr_line.tag  = mem_addr[31:IDX_W+2];
            wr_line.data = mem_rdata;
        end
    end

    dcache_array u_array (
        .Clk     (Clk),
        .Rst     (Rst),
        .rd_idx  (req_idx),
        .rd_line (rd_line),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_line (wr_line)
    );

    // Hits and the fill cycle bypass straight to the pipeline; otherwise the last load is held.
    always_comb begin
        StallMem  = 1'b0;
        ReadDataM = rdata_q;
        case (state)
            IDLE: begin
                StallMem = load_miss || store;
                if (load_hit) ReadDataM = rd_line.data;
            end
            RD_MISS: begin
                StallMem = !mem_ready;
                if (mem_ready) ReadDataM = mem_rdata;
            end
            WR_THRU: StallMem = !mem_ready;
            default: StallMem = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state         <= IDLE;
            mem_read_req  <= 1'b0;
            mem_write_req <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            rdata_q       <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_hit) begin
                        rdata_q <= rd_line.data;
                        if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
                    end else if (load_miss) begin
                        mem_addr     <= {AddressM[31:2], 2'b00};
                        mem_read_req <= 1'b1;
                        state        <= RD_MISS;
                        if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
                    end else if (store) begin
                        mem_addr      <= {AddressM[31:2], 2'b00};
                        mem_wdata     <= WriteDataM;
                        mem_write_req <= 1'b1;
                        state         <= WR_THRU;
                    end
                end
                RD_MISS: begin
                    if (mem_ready) begin
                        rdata_q      <= mem_rdata;
                        mem_read_req <= 1'b0;
                        state        <= IDLE;
                    end
                end
                WR_THRU: begin
                    if (mem_ready) begin
                        mem_write_req <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_wt.sv
// Directed plus randomized bench for dcache_wt against a behavioural cache/memory model.
module tb_dcache_wt;
    localparam int LINES = 16;
    localparam int IDXB  = 4;
    localparam int CW    = 4;
    localparam int CMAX  = 15;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [31:0]   AddressM;
    logic          MemtoRegM;
    logic          MemWriteM;
    logic [31:0]   WriteDataM;
    logic [31:0]   ReadDataM;
    logic          StallMem;
    logic          mem_read_req;
    logic          mem_write_req;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ready;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    int checks   = 0;
    int failures = 0;

    bit          refValid [LINES];
    logic [31:0] refTag   [LINES];
    logic [31:0] refData  [LINES];
    logic [31:0] memModel [logic [31:0]];
    int          refHits;
    int          refMisses;
    logic [31:0] lastRead;

    dcache_wt #(.CNT_W(CW)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .AddressM      (AddressM),
        .MemtoRegM     (MemtoRegM),
        .MemWriteM     (MemWriteM),
        .WriteDataM    (WriteDataM),
        .ReadDataM     (ReadDataM),
        .StallMem      (StallMem),
        .mem_read_req  (mem_read_req),
        .mem_write_req (mem_write_req),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (MemtoRegM && MemWriteM) $display("[TB] illegal stimulus: load and store requested together");
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic stepEdge();
        @(posedge Clk);
        #1;
    endtask

    task automatic idleInputs();
        MemtoRegM  = 1'b0;
        MemWriteM  = 1'b0;
        AddressM   = 32'h0;
        WriteDataM = 32'h0;
    endtask

    task automatic resetModel();
        for (int i = 0; i < LINES; i++) refValid[i] = 1'b0;
        refHits   = 0;
        refMisses = 0;
        lastRead  = 32'h0;
    endtask

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (!memModel.exists(a)) memModel[a] = $urandom;
        return memModel[a];
    endfunction

    // One load or store, with the memory answering after lat cycles of request.
    task automatic applyStimulus(input bit isLoad, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int lat, input bit scramble);
        int          idx;
        logic [31:0] tag;
        logic [31:0] word;
        logic [31:0] rdat;
        bit          hit;
        int          stalls;
        idx  = int'((addr >> 2) % LINES);
        tag  = addr >> (2 + IDXB);
        word = addr & 32'hFFFF_FFFC;
        hit  = refValid[idx] && (refTag[idx] == tag);
        AddressM   = addr;
        MemtoRegM  = isLoad;
        MemWriteM  = !isLoad;
        WriteDataM = wdata;
        @(negedge Clk);
        if (isLoad && hit) begin
            checkOutput("hit_stall", StallMem, 0);
            checkOutput("hit_data", ReadDataM, refData[idx]);
            checkOutput("hit_noreq", {mem_read_req, mem_write_req}, 0);
            if (refHits < CMAX) refHits++;
            lastRead = refData[idx];
            stepEdge();
            idleInputs();
            checkOutput("hit_count", hit_count, refHits);
            checkOutput("hold_data", ReadDataM, lastRead);
            return;
        end
        checkOutput("req_stall", StallMem, 1);
        if (isLoad && refMisses < CMAX) refMisses++;
        stepEdge();
        if (scramble) begin
            AddressM   = $urandom;
            WriteDataM = $urandom;
            MemtoRegM  = 1'($urandom_range(0, 1));
            MemWriteM  = 1'b0;
        end else begin
            idleInputs();
        end
        stalls = 1;
        rdat   = isLoad ? memRead(word) : 32'h0;
        for (int n = 1; n <= lat; n++) begin
            if (n == lat) begin
                mem_ready = 1'b1;
                mem_rdata = isLoad ? rdat : $urandom;
            end else begin
                mem_rdata = $urandom;
            end
            @(negedge Clk);
            if (StallMem) stalls++;
            if (n == 1) begin
                checkOutput("mem_addr", mem_addr, word);
                checkOutput("req_kind", {mem_read_req, mem_write_req}, isLoad ? 2 : 1);
                if (!isLoad) checkOutput("mem_wdata", mem_wdata, wdata);
            end
            if (n == lat) begin
                checkOutput("ready_stall", StallMem, 0);
                if (isLoad) checkOutput("bypass_data", ReadDataM, rdat);
            end
            stepEdge();
            mem_ready = 1'b0;
        end
        idleInputs();
        checkOutput("stall_cycles", stalls, lat);
        if (isLoad) begin
            refValid[idx] = 1'b1;
            refTag[idx]   = tag;
            refData[idx]  = rdat;
            lastRead      = rdat;
        end else begin
            memModel[word] = wdata;
            if (hit) refData[idx] = wdata;
        end
        @(negedge Clk);
        checkOutput("back_idle", {StallMem, mem_read_req, mem_write_req}, 0);
        checkOutput("hold_after", ReadDataM, lastRead);
        checkOutput("miss_count", miss_count, refMisses);
        checkOutput("hit_keep", hit_count, refHits);
        stepEdge();
    endtask

    initial begin
        Rst       = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        idleInputs();
        resetModel();
        #2;
        checkOutput("rst_stall", StallMem, 0);
        checkOutput("rst_reqs", {mem_read_req, mem_write_req}, 0);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_wdata", mem_wdata, 0);
        checkOutput("rst_rdata", ReadDataM, 0);
        checkOutput("rst_hits", hit_count, 0);
        checkOutput("rst_misses", miss_count, 0);
        @(negedge Clk);
        Rst = 1'b1;
        stepEdge();

        memModel[32'h40] = 32'hDEADBEEF;
        applyStimulus(1'b1, 32'h40, 32'h0, 20, 1'b0);
        checkOutput("cold_fill", refData[0], 32'hDEADBEEF);
        applyStimulus(1'b1, 32'h40, 32'h0, 20, 1'b0);
        applyStimulus(1'b0, 32'h40, 32'h12345678, 20, 1'b0);
        applyStimulus(1'b1, 32'h40, 32'h0, 20, 1'b0);
        applyStimulus(1'b0, 32'h80, 32'hCAFE0080, 5, 1'b0);
        applyStimulus(1'b1, 32'h80, 32'h0, 5, 1'b0);
        applyStimulus(1'b1, 32'h04, 32'h0, 4, 1'b0);
        applyStimulus(1'b1, 32'h44, 32'h0, 4, 1'b0);
        applyStimulus(1'b1, 32'h04, 32'h0, 4, 1'b0);

        for (int k = 0; k < 80; k++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 7)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 9) < 7, a, $urandom, $urandom_range(1, 8), 1'($urandom_range(0, 1)));
        end

        for (int k = 0; k < 18; k++) applyStimulus(1'b1, 32'h04, 32'h0, 3, 1'b0);
        checkOutput("hit_saturated", hit_count, CMAX);

        AddressM  = 32'h1000;
        MemtoRegM = 1'b1;
        stepEdge();
        idleInputs();
        repeat (3) stepEdge();
        #1;
        Rst = 1'b0;
        #1;
        checkOutput("midrst_reqs", {mem_read_req, mem_write_req}, 0);
        checkOutput("midrst_stall", StallMem, 0);
        checkOutput("midrst_counts", {hit_count, miss_count}, 0);
        checkOutput("midrst_rdata", ReadDataM, 0);
        resetModel();
        @(negedge Clk);
        Rst = 1'b1;
        stepEdge();
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        @(negedge Clk);
        checkOutput("late_ready_stall", StallMem, 0);
        checkOutput("late_ready_reqs", {mem_read_req, mem_write_req}, 0);
        stepEdge();
        mem_ready = 1'b0;
        checkOutput("late_ready_rdata", ReadDataM, 0);
        applyStimulus(1'b1, 32'h40, 32'h0, 20, 1'b0);
        checkOutput("post_rst_miss", miss_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
